id_ex_ctrl: RTL and testbench

Decode-to-execute control stage of the pipelined MIPS core. Decodes the instruction in ID into main-control and 3-bit ALU select signals, then registers them with the instruction's register fields and sign-extended immediate into the ID/EX boundary. The registered `alucontrol_e` drives the ALU `select` input directly. Supports hold (stall) and bubble (flush) from the hazard unit.

---
 rtl/ctrl_pkg.sv | 61 ++++++
 rtl/id_ex_ctrl_if.sv | 34 +++
 rtl/id_ex_ctrl_aludec.sv | 34 +++
 rtl/id_ex_ctrl.sv | 129 ++++++++++++
 tb/tb_id_ex_ctrl.sv | 182 ++++++++++++++++++
 5 files changed

// File: rtl/ctrl_pkg.sv
// Shared types for the ID/EX control stage: ALU selects, ALU op classes,
// MIPS opcode/funct encodings and the registered stage contents.
package ctrl_pkg;

    typedef enum logic [2:0] {
        AND = 3'b000,
        OR  = 3'b001,
        ADD = 3'b010,
        SUB = 3'b110,
        SLT = 3'b111
    } alu_sel_t;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } aluop_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    typedef struct packed {
        logic     regwrite;
        logic     memtoreg;
        logic     memwrite;
        logic     alusrc;
        logic     regdst;
        logic     branch;
        logic     jump;
        alu_sel_t alucontrol;
    } ctrl_t;

    typedef struct packed {
        ctrl_t       ctrl;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic        valid;
        logic        illegal;
    } stage_t;

    // A bubble is all-zero except the ALU select, which must stay a defined code.
    function automatic stage_t bubble_stage();
        stage_t s;
        s = '0;
        s.ctrl.alucontrol = ADD;
        return s;
    endfunction

endpackage

// File: rtl/id_ex_ctrl_if.sv
// Signal bundle around the ID/EX control stage; master drives the ID side,
// slave is the stage itself.
interface id_ex_ctrl_if;
    logic [31:0] instr_d;
    logic        valid_d;
    logic        stall_e;
    logic        flush_e;
    logic        regwrite_e;
    logic        memtoreg_e;
    logic        memwrite_e;
    logic        alusrc_e;
    logic        regdst_e;
    logic        branch_e;
    logic        jump_e;
    logic [2:0]  alucontrol_e;
    logic [4:0]  rs_e;
    logic [4:0]  rt_e;
    logic [4:0]  rd_e;
    logic [31:0] imm_e;
    logic        valid_e;
    logic        illegal_e;

    modport master (
        output instr_d, valid_d, stall_e, flush_e,
        input  regwrite_e, memtoreg_e, memwrite_e, alusrc_e, regdst_e, branch_e,
               jump_e, alucontrol_e, rs_e, rt_e, rd_e, imm_e, valid_e, illegal_e
    );

    modport slave (
        input  instr_d, valid_d, stall_e, flush_e,
        output regwrite_e, memtoreg_e, memwrite_e, alusrc_e, regdst_e, branch_e,
               jump_e, alucontrol_e, rs_e, rt_e, rd_e, imm_e, valid_e, illegal_e
    );
endinterface

// File: rtl/id_ex_ctrl_aludec.sv
// ALU decoder: maps the op class and R-type funct to an ALU select and flags
// funct values the ALU does not implement.
module aludec
    import ctrl_pkg::*;
(
    input  aluop_t     aluop,
    input  logic [5:0] funct,
    output alu_sel_t   alucontrol,
    output logic       illegal
);

    // NOTE: every output gets a default before the case so no path leaves a
    // value unassigned, which would otherwise infer a latch.
    always_comb begin
        alucontrol = ADD;
        illegal    = 1'b0;
        unique case (aluop)
            ALUOP_ADD: alucontrol = ADD;
            ALUOP_SUB: alucontrol = SUB;
            ALUOP_FUNCT: begin
                case (funct)
                    FN_ADD:  alucontrol = ADD;
                    FN_SUB:  alucontrol = SUB;
                    FN_AND:  alucontrol = AND;
                    FN_OR:   alucontrol = OR;
                    FN_SLT:  alucontrol = SLT;
                    default: illegal    = 1'b1;
                endcase
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/id_ex_ctrl.sv
// ID/EX control stage: main decode of instr_d plus the ID/EX pipeline
// register with synchronous reset, flush (bubble) and stall (hold).
module id_ex_ctrl
    import ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr_d,
    input  logic        valid_d,
    input  logic        stall_e,
    input  logic        flush_e,
    output logic        regwrite_e,
    output logic        memtoreg_e,
    output logic        memwrite_e,
    output logic        alusrc_e,
    output logic        regdst_e,
    output logic        branch_e,
    output logic        jump_e,
    output logic [2:0]  alucontrol_e,
    output logic [4:0]  rs_e,
    output logic [4:0]  rt_e,
    output logic [4:0]  rd_e,
    output logic [31:0] imm_e,
    output logic        valid_e,
    output logic        illegal_e
);

    logic [5:0] opcode;
    logic [5:0] funct;
    aluop_t     aluop;
    alu_sel_t   alu_sel;
    logic       funct_illegal;
    logic       op_illegal;
    logic       is_rtype;
    logic       illegal;
    ctrl_t      ctrl_dec;
    stage_t     stage_d;
    stage_t     stage_q;

    assign opcode = instr_d[31:26];
    assign funct  = instr_d[5:0];

    aludec u_aludec (
        .aluop      (aluop),
        .funct      (funct),
        .alucontrol (alu_sel),
        .illegal    (funct_illegal)
    );

    always_comb begin
        ctrl_dec   = '0;
        aluop      = ALUOP_ADD;
        op_illegal = 1'b0;
        is_rtype   = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                is_rtype        = 1'b1;
                ctrl_dec.regwrite = 1'b1;
                ctrl_dec.regdst   = 1'b1;
                aluop           = ALUOP_FUNCT;
            end
            OP_LW: begin
                ctrl_dec.regwrite = 1'b1;
                ctrl_dec.alusrc   = 1'b1;
                ctrl_dec.memtoreg = 1'b1;
            end
            OP_SW: begin
                ctrl_dec.alusrc   = 1'b1;
                ctrl_dec.memwrite = 1'b1;
            end
            OP_BEQ: begin
                ctrl_dec.branch = 1'b1;
                aluop           = ALUOP_SUB;
            end
            OP_ADDI: begin
                ctrl_dec.regwrite = 1'b1;
                ctrl_dec.alusrc   = 1'b1;
            end
            OP_J:    ctrl_dec.jump = 1'b1;
            default: op_illegal = 1'b1;
        endcase
        ctrl_dec.alucontrol = alu_sel;

        illegal = op_illegal | (is_rtype & funct_illegal);
        // Unsupported or non-valid instructions must not enable anything downstream.
        if (illegal || !valid_d) begin
            ctrl_dec = '0;
            ctrl_dec.alucontrol = ADD;
        end
    end

    always_comb begin
        stage_d = stage_q;
        if (flush_e) begin
            stage_d = bubble_stage();
        end else if (!stall_e) begin
            stage_d.ctrl    = ctrl_dec;
            stage_d.rs      = instr_d[25:21];
            stage_d.rt      = instr_d[20:16];
            stage_d.rd      = instr_d[15:11];
            stage_d.imm     = {{16{instr_d[15]}}, instr_d[15:0]};
            stage_d.valid   = valid_d;
            stage_d.illegal = valid_d & illegal;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (reset) stage_q <= bubble_stage();
        else       stage_q <= stage_d;
    end

    assign regwrite_e   = stage_q.ctrl.regwrite;
    assign memtoreg_e   = stage_q.ctrl.memtoreg;
    assign memwrite_e   = stage_q.ctrl.memwrite;
    assign alusrc_e     = stage_q.ctrl.alusrc;
    assign regdst_e     = stage_q.ctrl.regdst;
    assign branch_e     = stage_q.ctrl.branch;
    assign jump_e       = stage_q.ctrl.jump;
    assign alucontrol_e = stage_q.ctrl.alucontrol;
    assign rs_e         = stage_q.rs;
    assign rt_e         = stage_q.rt;
    assign rd_e         = stage_q.rd;
    assign imm_e        = stage_q.imm;
    assign valid_e      = stage_q.valid;
    assign illegal_e    = stage_q.illegal;

endmodule

// File: tb/tb_id_ex_ctrl.sv
// Self-checking bench for id_ex_ctrl: decode vector table plus stall, flush
// and reset sequences, scored through an expected-value queue.
module tb_id_ex_ctrl;

    typedef struct packed {
        logic        regwrite;
        logic        memtoreg;
        logic        memwrite;
        logic        alusrc;
        logic        regdst;
        logic        branch;
        logic        jump;
        logic [2:0]  alu;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic        valid;
        logic        illegal;
    } obs_t;

    typedef struct {
        string       name;
        logic [31:0] instr;
        logic        valid;
        obs_t        exp;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad = 0;

    obs_t  exp_q[$];
    string name_q[$];
    vec_t  vecs[$];

    id_ex_ctrl_if bus ();

    id_ex_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .instr_d      (bus.instr_d),
        .valid_d      (bus.valid_d),
        .stall_e      (bus.stall_e),
        .flush_e      (bus.flush_e),
        .regwrite_e   (bus.regwrite_e),
        .memtoreg_e   (bus.memtoreg_e),
        .memwrite_e   (bus.memwrite_e),
        .alusrc_e     (bus.alusrc_e),
        .regdst_e     (bus.regdst_e),
        .branch_e     (bus.branch_e),
        .jump_e       (bus.jump_e),
        .alucontrol_e (bus.alucontrol_e),
        .rs_e         (bus.rs_e),
        .rt_e         (bus.rt_e),
        .rd_e         (bus.rd_e),
        .imm_e        (bus.imm_e),
        .valid_e      (bus.valid_e),
        .illegal_e    (bus.illegal_e)
    );

    always #5 clk = ~clk;

    function automatic obs_t mk(input logic [6:0] en, input logic [2:0] alu,
                                input logic [4:0] rs, input logic [4:0] rt,
                                input logic [4:0] rd, input logic [31:0] imm,
                                input logic valid, input logic illegal);
        obs_t o;
        {o.regwrite, o.memtoreg, o.memwrite, o.alusrc, o.regdst, o.branch, o.jump} = en;
        o.alu = alu; o.rs = rs; o.rt = rt; o.rd = rd; o.imm = imm;
        o.valid = valid; o.illegal = illegal;
        return o;
    endfunction

    function automatic obs_t sample();
        obs_t o;
        o = '{bus.regwrite_e, bus.memtoreg_e, bus.memwrite_e, bus.alusrc_e,
              bus.regdst_e, bus.branch_e, bus.jump_e, bus.alucontrol_e,
              bus.rs_e, bus.rt_e, bus.rd_e, bus.imm_e, bus.valid_e, bus.illegal_e};
        return o;
    endfunction

    task automatic check(input string name, input obs_t got, input obs_t want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got en=%b alu=%b rs=%0d rt=%0d rd=%0d imm=%h v=%b ill=%b, want en=%b alu=%b rs=%0d rt=%0d rd=%0d imm=%h v=%b ill=%b",
                name,
                {got.regwrite, got.memtoreg, got.memwrite, got.alusrc, got.regdst, got.branch, got.jump},
                got.alu, got.rs, got.rt, got.rd, got.imm, got.valid, got.illegal,
                {want.regwrite, want.memtoreg, want.memwrite, want.alusrc, want.regdst, want.branch, want.jump},
                want.alu, want.rs, want.rt, want.rd, want.imm, want.valid, want.illegal);
        end
    endtask

    // Drive inputs, queue the expectation, advance one edge and score it.
    task automatic step(input string name, input logic rst, input logic [31:0] instr,
                        input logic valid, input logic stall, input logic flush,
                        input obs_t want);
        reset       = rst;
        bus.instr_d = instr;
        bus.valid_d = valid;
        bus.stall_e = stall;
        bus.flush_e = flush;
        exp_q.push_back(want);
        name_q.push_back(name);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s: scoreboard empty, want one entry", name);
        end else begin
            check(name_q.pop_front(), sample(), exp_q.pop_front());
        end
    endtask

    obs_t bubble, add_o, lw_o, addu_o;

    initial begin
        // enables order: regwrite memtoreg memwrite alusrc regdst branch jump
        bubble = mk(7'b0000000, 3'b010, 5'd0, 5'd0, 5'd0, 32'h0, 1'b0, 1'b0);
        add_o  = mk(7'b1000100, 3'b010, 5'd1, 5'd2, 5'd3, 32'h0000_1820, 1'b1, 1'b0);
        lw_o   = mk(7'b1101000, 3'b010, 5'd1, 5'd2, 5'd31, 32'hFFFF_FFFC, 1'b1, 1'b0);
        addu_o = mk(7'b0000000, 3'b010, 5'd1, 5'd2, 5'd3, 32'h0000_1821, 1'b1, 1'b1);

        vecs.push_back('{"add",   32'h0022_1820, 1'b1, add_o});
        vecs.push_back('{"lw",    32'h8C22_FFFC, 1'b1, lw_o});
        vecs.push_back('{"sw",    32'hAC22_0008, 1'b1, mk(7'b0011000, 3'b010, 5'd1, 5'd2, 5'd0, 32'h8, 1'b1, 1'b0)});
        vecs.push_back('{"beq",   32'h1022_0003, 1'b1, mk(7'b0000010, 3'b110, 5'd1, 5'd2, 5'd0, 32'h3, 1'b1, 1'b0)});
        vecs.push_back('{"addi",  32'h2022_FFFF, 1'b1, mk(7'b1001000, 3'b010, 5'd1, 5'd2, 5'd31, 32'hFFFF_FFFF, 1'b1, 1'b0)});
        vecs.push_back('{"j",     32'h0800_0010, 1'b1, mk(7'b0000001, 3'b010, 5'd0, 5'd0, 5'd0, 32'h10, 1'b1, 1'b0)});
        vecs.push_back('{"slt",   32'h0022_182A, 1'b1, mk(7'b1000100, 3'b111, 5'd1, 5'd2, 5'd3, 32'h182A, 1'b1, 1'b0)});
        vecs.push_back('{"sub",   32'h0022_1822, 1'b1, mk(7'b1000100, 3'b110, 5'd1, 5'd2, 5'd3, 32'h1822, 1'b1, 1'b0)});
        vecs.push_back('{"and",   32'h0022_1824, 1'b1, mk(7'b1000100, 3'b000, 5'd1, 5'd2, 5'd3, 32'h1824, 1'b1, 1'b0)});
        vecs.push_back('{"or",    32'h0022_1825, 1'b1, mk(7'b1000100, 3'b001, 5'd1, 5'd2, 5'd3, 32'h1825, 1'b1, 1'b0)});
        vecs.push_back('{"addu",  32'h0022_1821, 1'b1, addu_o});
        vecs.push_back('{"badop", 32'hFC00_0000, 1'b1, mk(7'b0000000, 3'b010, 5'd0, 5'd0, 5'd0, 32'h0, 1'b1, 1'b1)});
        vecs.push_back('{"nv_add", 32'h0022_1820, 1'b0, mk(7'b0000000, 3'b010, 5'd1, 5'd2, 5'd3, 32'h1820, 1'b0, 1'b0)});
        vecs.push_back('{"nv_bad", 32'hFC00_8000, 1'b0, mk(7'b0000000, 3'b010, 5'd0, 5'd0, 5'd16, 32'hFFFF_8000, 1'b0, 1'b0)});

        reset = 1'b1;
        bus.instr_d = 32'h0;
        bus.valid_d = 1'b0;
        bus.stall_e = 1'b0;
        bus.flush_e = 1'b0;
        @(posedge clk);
        step("reset", 1'b1, 32'h0022_1820, 1'b1, 1'b0, 1'b0, bubble);

        foreach (vecs[i])
            step(vecs[i].name, 1'b0, vecs[i].instr, vecs[i].valid, 1'b0, 1'b0, vecs[i].exp);

        // Hold add across three stalled edges while the ID instruction changes.
        step("ld_add",  1'b0, 32'h0022_1820, 1'b1, 1'b0, 1'b0, add_o);
        step("stall1",  1'b0, 32'h8C22_FFFC, 1'b1, 1'b1, 1'b0, add_o);
        step("stall2",  1'b0, 32'h1022_0003, 1'b1, 1'b1, 1'b0, add_o);
        step("stall3",  1'b0, 32'h0022_1821, 1'b1, 1'b1, 1'b0, add_o);
        step("stflush", 1'b0, 32'h0022_1820, 1'b1, 1'b1, 1'b1, bubble);

        // An illegal instruction stays flagged through a stall; flush alone bubbles.
        step("ld_addu", 1'b0, 32'h0022_1821, 1'b1, 1'b0, 1'b0, addu_o);
        step("st_ill1", 1'b0, 32'h0022_1820, 1'b1, 1'b1, 1'b0, addu_o);
        step("st_ill2", 1'b0, 32'h0022_1820, 1'b0, 1'b1, 1'b0, addu_o);
        step("flush",   1'b0, 32'h0022_1820, 1'b1, 1'b0, 1'b1, bubble);

        // Reset during a stall with lw held, then release.
        step("ld_add2", 1'b0, 32'h0022_1820, 1'b1, 1'b0, 1'b0, add_o);
        step("rst_stl", 1'b1, 32'h8C22_FFFC, 1'b1, 1'b1, 1'b0, bubble);
        step("post_rst", 1'b0, 32'h8C22_FFFC, 1'b1, 1'b0, 1'b0, lw_o);

        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: %0d entries left, want 0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
